bus_arb_mux: RTL and testbench
==============================

Name: bus_arb_mux

Overview:
- Parametrised, registered successor to the datapath's combinational bus multiplexer.
- Takes NUM_SRC source words and per-source out-enable requests from the control unit.
- Arbitrates among asserted requests by fixed priority or round-robin, then drives a registered bus word with grant, valid and contention status.
- Sits between the register file, special registers (HI, LO, Z, PC, MDR, InPort, Y, C) and the shared datapath bus.

Parameters:
- WIDTH, 32, bit width of each source word and of the bus.
- NUM_SRC, 25, number of bus sources; legal range 2..63.
- MODE, 0, arbitration: 0 = fixed priority (lowest index wins), 1 = round-robin.
- HOLD, 1, idle behaviour: 1 = bus_out keeps its last value, 0 = bus_out is forced to zero.
- SEL_W (derived localparam), $clog2(NUM_SRC+1), width of grant_idx.

Ports:
- clk  input  1  rising-edge clock.
- clr_n  input  1  asynchronous active-low reset.
- src_data  input  NUM_SRC*WIDTH  flattened source words; source i occupies bits [i*WIDTH +: WIDTH].
- src_req  input  NUM_SRC  out-enable per source; one-hot is intended, but any pattern is legal.
- clear_err  input  1  synchronous clear of contention_sticky.
- bus_out  output  WIDTH  registered bus word.
- bus_valid  output  1  bus_out was driven by a grant in the current cycle.
- grant  output  NUM_SRC  registered one-hot grant vector.
- grant_idx  output  SEL_W  encoded grant: 0 = none, i+1 = source i.
- contention  output  1  one-cycle flag: more than one request was sampled.
- contention_sticky  output  1  latched contention.

Behaviour:
- Reset (clr_n=0, asynchronous): the following take effect immediately and hold while clr_n is low:
  - bus_out=0, bus_valid=0, grant=0, grant_idx=0
  - contention=0, contention_sticky=0
  - round-robin pointer last=NUM_SRC-1, so source 0 has first priority after reset.
- Latency: exactly one cycle. src_req and src_data sampled at edge k appear on bus_out, grant, grant_idx and bus_valid after edge k.
- All outputs are registered. No combinational path exists from inputs to outputs.
- Winner selection when MODE=0: the lowest asserted index of src_req.
- Winner selection when MODE=1:
  - Winner is the first asserted index scanning last+1, last+2, … with wrap from NUM_SRC-1 to 0.
  - last is updated to the winner only on cycles with a grant.
  - With a single persistent request, the same source wins every cycle.
- Grant cycle (src_req≠0):
  - bus_out = src_data word of the winner.
  - grant = one-hot of the winner, grant_idx = winner+1, bus_valid=1.
- Idle cycle (src_req=0):
  - grant=0, grant_idx=0, bus_valid=0.
  - bus_out keeps its previous value if HOLD=1; otherwise bus_out=0.
  - last is unchanged.
- Contention:
  - contention = 1 after an edge where popcount(src_req)>1; otherwise 0.
  - The winner is still granted normally under contention.
- contention_sticky:
  - Set on any edge where contention is detected.
  - Cleared on an edge where clear_err=1 and no new contention is detected.
  - Set has priority over clear when both occur on the same edge.
- Source data is sampled only at the grant edge. Changes in a granted source's data after the edge do not affect bus_out until the next sample.
- Reset mid-operation: all state, including last, returns to reset values at once. The first post-reset grant in MODE=1 favours source 0.
- Boundary cases:
  - A request on source NUM_SRC-1 encodes grant_idx=NUM_SRC.
  - In MODE=1, the wrap from NUM_SRC-1 to index 0 must work.
- Elaboration error if NUM_SRC<2 or NUM_SRC>63.

Test Plan:
1. Reset, then one-hot requests: MODE=0, src_data[i]=32'hA000_0000+i; assert src_req=1<<3 for one cycle -> next cycle bus_out=32'hA000_0003, grant=1<<3, grant_idx=4, bus_valid=1, contention=0.
2. Idle hold versus zero: after test 1, drive src_req=0.
   - HOLD=1 -> bus_out stays 32'hA000_0003, bus_valid=0, grant_idx=0.
   - Rerun with HOLD=0 -> bus_out=0.
3. Fixed-priority contention: MODE=0, src_req bits 5 and 17 set -> grant_idx=6, bus_out=32'hA000_0005, contention=1 for one cycle, contention_sticky=1.
   - Then pulse clear_err with single requests -> sticky returns to 0.
   - Pulse clear_err together with a contended request -> sticky stays 1.
4. Round-robin fairness: MODE=1, NUM_SRC=25, hold src_req bits 0, 1 and 24 for 6 cycles.
   - Required grant_idx sequence: 1, 2, 25, 1, 2, 25.
   - contention=1 on every cycle.
5. Round-robin wrap and idle: MODE=1, grant source 24 once, then idle 3 cycles, then request bits 0 and 24 -> grant_idx=1; last is unchanged across the idle cycles.
6. Asynchronous reset mid-stream: in MODE=1 with requests active, drop clr_n between clock edges.
   - All outputs go to 0 immediately.
   - After release with bits 0 and 1 requested, the first grant_idx=1.

Source files
------------

// File: rtl/bus_arb_mux.sv
// Registered bus multiplexer with fixed-priority or round-robin arbitration
// among per-source out-enable requests, plus contention status.
module bus_arb_mux #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 25,
  parameter int MODE    = 0,
  parameter int HOLD    = 1,
  localparam int SEL_W  = $clog2(NUM_SRC + 1)
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic [NUM_SRC*WIDTH-1:0]   src_data,
  input  logic [NUM_SRC-1:0]         src_req,
  input  logic                       clear_err,
  output logic [WIDTH-1:0]           bus_out,
  output logic                       bus_valid,
  output logic [NUM_SRC-1:0]         grant,
  output logic [SEL_W-1:0]           grant_idx,
  output logic                       contention,
  output logic                       contention_sticky
);

  generate
    if (NUM_SRC < 2 || NUM_SRC > 63) begin : g_bad_num_src
      $error("bus_arb_mux: NUM_SRC must be within 2..63");
    end
  endgenerate

  logic [SEL_W-1:0] last;
  logic             found;
  int               win;
  int               cand;
  logic             multi;

  // Round-robin scans last+1, last+2, ... with wrap; fixed priority takes
  // the lowest asserted index.
  always_comb begin
    found = 1'b0;
    win   = 0;
    cand  = 0;
    if (MODE == 0) begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (((src_req >> i) & NUM_SRC'(1)) != '0) begin
          win   = i;
          found = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        cand = int'(last) + k;
        if (cand >= NUM_SRC) cand = cand - NUM_SRC;
        if (!found && (((src_req >> cand) & NUM_SRC'(1)) != '0)) begin
          win   = cand;
          found = 1'b1;
        end
      end
    end
  end

  assign multi = |(src_req & (src_req - NUM_SRC'(1)));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bus_out           <= '0;
      bus_valid         <= 1'b0;
      grant             <= '0;
      grant_idx         <= '0;
      contention        <= 1'b0;
      contention_sticky <= 1'b0;
      last              <= SEL_W'(NUM_SRC - 1);
    end else begin
      contention <= multi;
      // A fresh contention wins over a simultaneous clear request.
      if (multi)          contention_sticky <= 1'b1;
      else if (clear_err) contention_sticky <= 1'b0;

      if (found) begin
        bus_out   <= WIDTH'(src_data >> (win * WIDTH));
        bus_valid <= 1'b1;
        grant     <= NUM_SRC'(1) << win;
        grant_idx <= SEL_W'(win + 1);
        last      <= SEL_W'(win);
      end else begin
        bus_valid <= 1'b0;
        grant     <= '0;
        grant_idx <= '0;
        if (HOLD == 0) bus_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_arb_mux.sv
// Bench for bus_arb_mux: three instances (fixed/hold, round-robin/hold,
// fixed/zero-idle) share stimulus and are checked against a behavioural model.
module tb_bus_arb_mux;
  localparam int N = 25;
  localparam int W = 32;
  localparam int SW = $clog2(N + 1);

  logic           clk = 1'b0;
  logic           clr_n;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_req;
  logic           clear_err;

  logic [W-1:0]  d_bus[3];
  logic          d_valid[3];
  logic [N-1:0]  d_grant[3];
  logic [SW-1:0] d_idx[3];
  logic          d_cont[3];
  logic          d_sticky[3];

  int cfg_mode[3] = '{0, 1, 0};
  int cfg_hold[3] = '{1, 1, 0};

  logic [W-1:0] m_bus[3];
  logic         m_valid[3];
  logic [N-1:0] m_grant[3];
  int           m_idx[3];
  logic         m_cont[3];
  logic         m_sticky[3];
  int           m_last[3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arb_mux #(.WIDTH(W), .NUM_SRC(N), .MODE(0), .HOLD(1)) u_fp (
    .clk(clk), .clr_n(clr_n), .src_data(src_data), .src_req(src_req),
    .clear_err(clear_err), .bus_out(d_bus[0]), .bus_valid(d_valid[0]),
    .grant(d_grant[0]), .grant_idx(d_idx[0]), .contention(d_cont[0]),
    .contention_sticky(d_sticky[0]));

  bus_arb_mux #(.WIDTH(W), .NUM_SRC(N), .MODE(1), .HOLD(1)) u_rr (
    .clk(clk), .clr_n(clr_n), .src_data(src_data), .src_req(src_req),
    .clear_err(clear_err), .bus_out(d_bus[1]), .bus_valid(d_valid[1]),
    .grant(d_grant[1]), .grant_idx(d_idx[1]), .contention(d_cont[1]),
    .contention_sticky(d_sticky[1]));

  bus_arb_mux #(.WIDTH(W), .NUM_SRC(N), .MODE(0), .HOLD(0)) u_z (
    .clk(clk), .clr_n(clr_n), .src_data(src_data), .src_req(src_req),
    .clear_err(clear_err), .bus_out(d_bus[2]), .bus_valid(d_valid[2]),
    .grant(d_grant[2]), .grant_idx(d_idx[2]), .contention(d_cont[2]),
    .contention_sticky(d_sticky[2]));

  typedef struct {
    logic [N-1:0] req;
    logic         clr;
    int           fp_idx;
    int           rr_idx;
    logic         cont;
    logic         sticky;
    logic [W-1:0] fp_bus;
    logic [W-1:0] z_bus;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int model_winner(input int mode, input logic [N-1:0] req, input int last);
    if (mode == 0) begin
      for (int i = 0; i < N; i++) if (req[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_bus[c] = '0; m_valid[c] = 1'b0; m_grant[c] = '0; m_idx[c] = 0;
      m_cont[c] = 1'b0; m_sticky[c] = 1'b0; m_last[c] = N - 1;
    end
  endtask

  task automatic model_step();
    int n, w;
    n = $countones(src_req);
    for (int c = 0; c < 3; c++) begin
      m_cont[c] = (n > 1);
      if (n > 1) m_sticky[c] = 1'b1;
      else if (clear_err) m_sticky[c] = 1'b0;
      if (n > 0) begin
        w = model_winner(cfg_mode[c], src_req, m_last[c]);
        m_bus[c] = src_data[w*W +: W];
        m_valid[c] = 1'b1;
        m_grant[c] = '0;
        m_grant[c][w] = 1'b1;
        m_idx[c] = w + 1;
        m_last[c] = w;
      end else begin
        m_valid[c] = 1'b0;
        m_grant[c] = '0;
        m_idx[c] = 0;
        if (cfg_hold[c] == 0) m_bus[c] = '0;
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bus_out[%0d]", c), 64'(d_bus[c]), 64'(m_bus[c]));
      chk($sformatf("bus_valid[%0d]", c), 64'(d_valid[c]), 64'(m_valid[c]));
      chk($sformatf("grant[%0d]", c), 64'(d_grant[c]), 64'(m_grant[c]));
      chk($sformatf("grant_idx[%0d]", c), 64'(d_idx[c]), 64'(m_idx[c]));
      chk($sformatf("contention[%0d]", c), 64'(d_cont[c]), 64'(m_cont[c]));
      chk($sformatf("sticky[%0d]", c), 64'(d_sticky[c]), 64'(m_sticky[c]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Called just after tick(); the whole pulse stays between clock edges.
  task automatic mid_reset();
    #2 clr_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rst_bus[%0d]", c), 64'(d_bus[c]), 64'd0);
      chk($sformatf("rst_idx[%0d]", c), 64'(d_idx[c]), 64'd0);
    end
    #2 clr_n = 1'b1;
  endtask

  task automatic base_data();
    for (int i = 0; i < N; i++) src_data[i*W +: W] = 32'hA000_0000 + 32'(i);
  endtask

  initial begin
    clr_n = 1'b0; src_req = '0; clear_err = 1'b0;
    base_data();
    model_reset();
    #12;
    compare_all();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("init_valid[%0d]", c), 64'(d_valid[c]), 64'd0);
      chk($sformatf("init_sticky[%0d]", c), 64'(d_sticky[c]), 64'd0);
    end
    @(negedge clk) clr_n = 1'b1;

    tbl.push_back('{25'h0000008, 1'b0,  4,  4, 1'b0, 1'b0, 32'hA000_0003, 32'hA000_0003});
    tbl.push_back('{25'h0000000, 1'b0,  0,  0, 1'b0, 1'b0, 32'hA000_0003, 32'h0});
    tbl.push_back('{25'h0020020, 1'b0,  6,  6, 1'b1, 1'b1, 32'hA000_0005, 32'hA000_0005});
    tbl.push_back('{25'h0000004, 1'b1,  3,  3, 1'b0, 1'b0, 32'hA000_0002, 32'hA000_0002});
    tbl.push_back('{25'h0020020, 1'b0,  6,  6, 1'b1, 1'b1, 32'hA000_0005, 32'hA000_0005});
    tbl.push_back('{25'h0020020, 1'b1,  6, 18, 1'b1, 1'b1, 32'hA000_0005, 32'hA000_0005});
    tbl.push_back('{25'h0000200, 1'b0, 10, 10, 1'b0, 1'b1, 32'hA000_0009, 32'hA000_0009});
    tbl.push_back('{25'h1000003, 1'b0,  1, 25, 1'b1, 1'b1, 32'hA000_0000, 32'hA000_0000});
    tbl.push_back('{25'h1000003, 1'b0,  1,  1, 1'b1, 1'b1, 32'hA000_0000, 32'hA000_0000});
    tbl.push_back('{25'h1000003, 1'b0,  1,  2, 1'b1, 1'b1, 32'hA000_0000, 32'hA000_0000});
    tbl.push_back('{25'h1000003, 1'b0,  1, 25, 1'b1, 1'b1, 32'hA000_0000, 32'hA000_0000});
    tbl.push_back('{25'h1000003, 1'b0,  1,  1, 1'b1, 1'b1, 32'hA000_0000, 32'hA000_0000});
    tbl.push_back('{25'h1000003, 1'b0,  1,  2, 1'b1, 1'b1, 32'hA000_0000, 32'hA000_0000});
    tbl.push_back('{25'h1000000, 1'b1, 25, 25, 1'b0, 1'b0, 32'hA000_0018, 32'hA000_0018});
    tbl.push_back('{25'h0000000, 1'b0,  0,  0, 1'b0, 1'b0, 32'hA000_0018, 32'h0});
    tbl.push_back('{25'h0000000, 1'b0,  0,  0, 1'b0, 1'b0, 32'hA000_0018, 32'h0});
    tbl.push_back('{25'h0000000, 1'b0,  0,  0, 1'b0, 1'b0, 32'hA000_0018, 32'h0});
    tbl.push_back('{25'h1000001, 1'b0,  1,  1, 1'b1, 1'b1, 32'hA000_0000, 32'hA000_0000});

    foreach (tbl[r]) begin
      src_req = tbl[r].req;
      clear_err = tbl[r].clr;
      tick();
      chk($sformatf("row%0d fp_idx", r), 64'(d_idx[0]), 64'(tbl[r].fp_idx));
      chk($sformatf("row%0d rr_idx", r), 64'(d_idx[1]), 64'(tbl[r].rr_idx));
      chk($sformatf("row%0d cont", r), 64'(d_cont[0]), 64'(tbl[r].cont));
      chk($sformatf("row%0d sticky", r), 64'(d_sticky[0]), 64'(tbl[r].sticky));
      chk($sformatf("row%0d fp_bus", r), 64'(d_bus[0]), 64'(tbl[r].fp_bus));
      chk($sformatf("row%0d z_bus", r), 64'(d_bus[2]), 64'(tbl[r].z_bus));
    end

    // Round-robin fairness from a fresh reset among sources 0, 1 and 24.
    src_req = '0; clear_err = 1'b0;
    tick();
    mid_reset();
    src_req = 25'h1000003;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rr_seq%0d idx", k), 64'(d_idx[1]), 64'((k % 3 == 0) ? 1 : (k % 3 == 1) ? 2 : 25));
      chk($sformatf("rr_seq%0d cont", k), 64'(d_cont[1]), 64'd1);
    end

    // Reset between edges while requests are active; source 0 wins first afterwards.
    mid_reset();
    src_req = 25'h0000003;
    tick();
    chk("post_rst rr_idx", 64'(d_idx[1]), 64'd1);
    chk("post_rst rr_bus", 64'(d_bus[1]), 64'hA000_0000);

    // Granted data changing after the edge must not leak through.
    src_req = 25'h0000000;
    src_data[0 +: W] = 32'h1234_5678;
    tick();
    chk("hold_after_change", 64'(d_bus[0]), 64'hA000_0000);

    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) src_data[i*W +: W] = $urandom;
      case ($urandom_range(0, 3))
        0: src_req = '0;
        1: src_req = N'(1) << $urandom_range(0, N - 1);
        2: src_req = N'($urandom) & N'($urandom) & N'($urandom);
        default: src_req = N'($urandom);
      endcase
      clear_err = ($urandom_range(0, 3) == 0);
      tick();
      if ($urandom_range(0, 49) == 0) mid_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
